// File: rtl/edge_pkg.sv
// Shared types and constants for the frame address generator and its
// neighbouring pixel-buffer and filter controllers.
package edge_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    RUN   = 3'd2,
    DRAIN = 3'd3,
    DONE  = 3'd4
  } fag_state_t;

  localparam int WORD_BYTES = 4;
  localparam int IDX_W      = 22;

endpackage

// File: rtl/word_counter.sv
// Word index counter with synchronous clear and terminal compares against
// the frame's word total; used for both the read and write walks.
module word_counter
  import edge_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             inc,
  input  logic [IDX_W-1:0] total,
  output logic [IDX_W-1:0] count,
  output logic             at_end,
  output logic             last
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (inc) begin
      count <= count + IDX_W'(1);
    end
  end

  // last: the word currently indexed is the final one of the frame
  assign at_end = (count == total);
  assign last   = ((count + IDX_W'(1)) == total);

endmodule

// File: rtl/frame_addr_gen.sv
// Walks a frame in raster order, issuing one word read per 4 packed pixels
// and one write per filtered result word; pulses done at frame end.
module frame_addr_gen
  import edge_pkg::*;
#(
  parameter int ADDRWIDTH  = 32,
  parameter int WORD_BYTES = edge_pkg::WORD_BYTES
) (
  input  logic                 ahb_hclk,
  input  logic                 rst,
  input  logic                 enable,
  input  logic [11:0]          width,
  input  logic [11:0]          height,
  input  logic [ADDRWIDTH-1:0] readStartAddress,
  input  logic [ADDRWIDTH-1:0] writeStartAddress,
  input  logic                 buf_full,
  output logic                 rd_req,
  output logic [ADDRWIDTH-1:0] rd_addr,
  input  logic                 rd_ack,
  input  logic                 res_valid,
  output logic                 res_ready,
  output logic                 wr_req,
  output logic [ADDRWIDTH-1:0] wr_addr,
  input  logic                 wr_ack,
  output logic                 busy,
  output logic                 done,
  output fag_state_t           state
);

  // Handshake: a transfer happens on any rising edge where req and ack are
  // both high; req and its address are held unchanged until that edge.

  fag_state_t       state_d;
  logic [23:0]      pixels;
  logic [IDX_W-1:0] total_calc;
  logic [IDX_W-1:0] total_words;
  logic [IDX_W-1:0] rd_idx;
  logic [IDX_W-1:0] wr_idx;
  logic             rd_at_end, rd_last, wr_at_end, wr_last;
  logic             rd_fire, wr_fire, rd_req_d, cnt_clear, wr_active;

  assign pixels     = 24'(width) * 24'(height);
  assign total_calc = IDX_W'((pixels + 24'd3) >> 2);
  assign rd_fire    = rd_req & rd_ack;
  assign wr_fire    = wr_req & wr_ack;
  assign cnt_clear  = (state == LOAD);
  assign wr_active  = (state == RUN) || (state == DRAIN);

  word_counter u_rd_cnt (
    .clk    (ahb_hclk),
    .rst    (rst),
    .clear  (cnt_clear),
    .inc    (rd_fire),
    .total  (total_words),
    .count  (rd_idx),
    .at_end (rd_at_end),
    .last   (rd_last)
  );

  word_counter u_wr_cnt (
    .clk    (ahb_hclk),
    .rst    (rst),
    .clear  (cnt_clear),
    .inc    (wr_fire),
    .total  (total_words),
    .count  (wr_idx),
    .at_end (wr_at_end),
    .last   (wr_last)
  );

  always_ff @(posedge ahb_hclk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      rd_req      <= 1'b0;
      total_words <= '0;
    end else begin
      state  <= state_d;
      rd_req <= rd_req_d;
      if (state == LOAD) begin
        total_words <= total_calc;
      end
    end
  end

  always_comb begin
    state_d  = state;
    rd_req_d = 1'b0;
    case (state)
      IDLE:    if (enable) state_d = LOAD;
      LOAD:    state_d = (total_calc == '0) ? DONE : RUN;
      RUN: begin
        // The write side may already be finished; then skip DRAIN entirely.
        if (rd_fire && rd_last) begin
          state_d = (wr_at_end || (wr_fire && wr_last)) ? DONE : DRAIN;
        end
        if (rd_req && !rd_ack) begin
          rd_req_d = 1'b1;
        end else begin
          rd_req_d = !buf_full && (rd_fire ? !rd_last : !rd_at_end);
        end
      end
      DRAIN:   if (wr_fire && wr_last) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy      = (state == LOAD) || (state == RUN) || (state == DRAIN);
    done      = (state == DONE);
    wr_req    = res_valid && wr_active && !wr_at_end;
    res_ready = wr_req && wr_ack;
    rd_addr   = '0;
    wr_addr   = '0;
    if (state == RUN) begin
      rd_addr = readStartAddress + ADDRWIDTH'(rd_idx) * ADDRWIDTH'(WORD_BYTES);
    end
    if (wr_active) begin
      wr_addr = writeStartAddress + ADDRWIDTH'(wr_idx) * ADDRWIDTH'(WORD_BYTES);
    end
  end

endmodule

// File: tb/tb_frame_addr_gen.sv
// Directed bench for frame_addr_gen: a per-cycle monitor checks requests
// against queues of expected addresses built from the frame geometry.
module tb_frame_addr_gen;
  import edge_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        enable = 1'b0;
  logic [11:0] width = '0;
  logic [11:0] height = '0;
  logic [31:0] readStartAddress = '0;
  logic [31:0] writeStartAddress = '0;
  logic        buf_full = 1'b0;
  logic        rd_req;
  logic [31:0] rd_addr;
  logic        rd_ack = 1'b0;
  logic        res_valid = 1'b0;
  logic        res_ready;
  logic        wr_req;
  logic [31:0] wr_addr;
  logic        wr_ack = 1'b0;
  logic        busy;
  logic        done;
  fag_state_t  state;

  frame_addr_gen dut (
    .ahb_hclk          (clk),
    .rst               (rst),
    .enable            (enable),
    .width             (width),
    .height            (height),
    .readStartAddress  (readStartAddress),
    .writeStartAddress (writeStartAddress),
    .buf_full          (buf_full),
    .rd_req            (rd_req),
    .rd_addr           (rd_addr),
    .rd_ack            (rd_ack),
    .res_valid         (res_valid),
    .res_ready         (res_ready),
    .wr_req            (wr_req),
    .wr_addr           (wr_addr),
    .wr_ack            (wr_ack),
    .busy              (busy),
    .done              (done),
    .state             (state)
  );

  // clock / reset
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  logic [31:0] rd_exp_q[$];
  logic [31:0] wr_exp_q[$];
  logic [31:0] rd_log[$];
  logic [31:0] wr_log[$];
  int          rd_req_cycles = 0;
  int          done_cnt = 0;
  int          done_base = 0;
  logic        frame_armed = 1'b0;
  logic        done_next = 1'b0;
  logic        zero_expect = 1'b0;
  logic        both_fire_seen = 1'b0;
  logic        prev_rd_req = 1'b0;
  logic        prev_rd_ack = 1'b0;
  logic        prev_buf_full = 1'b0;
  logic [31:0] prev_rd_addr = '0;
  logic        exp_done;

  int          rd_ack_delay = 0;
  int          rd_wait = 0;
  logic        res_on = 1'b0;
  logic        wr_ack_on = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] log_at(input logic [31:0] q[$], input int i);
    return (q.size() > i) ? q[i] : 32'hDEAD_BEEF;
  endfunction

  // driver: master-port acks and filter results
  always @(negedge clk) begin
    if (rst) begin
      rd_ack  = 1'b0;
      rd_wait = 0;
    end else begin
      if (rd_ack) rd_wait = 0;
      if (rd_req) begin
        rd_ack = (rd_wait >= rd_ack_delay);
        rd_wait++;
      end else begin
        rd_ack  = 1'b0;
        rd_wait = 0;
      end
    end
    res_valid = res_on;
    wr_ack    = wr_ack_on;
  end

  // scoreboard / compare process, sampled just before each rising edge
  always @(negedge clk) begin
    #4;
    if (rst) begin
      done_next     = 1'b0;
      prev_rd_req   = 1'b0;
      prev_rd_ack   = 1'b0;
      prev_buf_full = 1'b0;
    end else begin
      exp_done  = done_next | zero_expect;
      done_next = 1'b0;
      chk("done", 32'(done), 32'(exp_done));
      if (done) chk("busy_in_done", 32'(busy), 32'd0);
      if (prev_rd_req && !prev_rd_ack) begin
        chk("rd_req_hold", 32'(rd_req), 32'd1);
        chk("rd_addr_hold", rd_addr, prev_rd_addr);
      end
      if (!prev_rd_req && prev_buf_full) chk("rd_rise_while_full", 32'(rd_req), 32'd0);
      if (rd_req) begin
        rd_req_cycles++;
        if (rd_exp_q.size() == 0) chk("rd_unexpected", 32'(rd_req), 32'd0);
        else chk("rd_addr", rd_addr, rd_exp_q[0]);
      end
      if (wr_req) begin
        if (wr_exp_q.size() == 0) chk("wr_unexpected", 32'(wr_req), 32'd0);
        else chk("wr_addr", wr_addr, wr_exp_q[0]);
      end
      chk("res_ready", 32'(res_ready), 32'(wr_req & wr_ack));
      if (rd_req && rd_ack && wr_req && wr_ack) both_fire_seen = 1'b1;
      if (rd_req && rd_ack && rd_exp_q.size() > 0) begin
        rd_log.push_back(rd_addr);
        void'(rd_exp_q.pop_front());
      end
      if (wr_req && wr_ack && wr_exp_q.size() > 0) begin
        wr_log.push_back(wr_addr);
        void'(wr_exp_q.pop_front());
      end
      if (frame_armed && rd_exp_q.size() == 0 && wr_exp_q.size() == 0) begin
        frame_armed = 1'b0;
        done_next   = 1'b1;
      end
      prev_rd_req   = rd_req;
      prev_rd_ack   = rd_ack;
      prev_buf_full = buf_full;
      prev_rd_addr  = rd_addr;
      if (done) done_cnt++;
    end
  end

  task automatic start_frame(input int w, input int h, input logic [31:0] rb, input logic [31:0] wb);
    int tot;
    tot = (w * h + 3) / 4;
    width = 12'(w);
    height = 12'(h);
    readStartAddress = rb;
    writeStartAddress = wb;
    rd_exp_q.delete();
    wr_exp_q.delete();
    rd_log.delete();
    wr_log.delete();
    rd_req_cycles = 0;
    both_fire_seen = 1'b0;
    for (int i = 0; i < tot; i++) begin
      rd_exp_q.push_back(rb + 32'(i) * 32'd4);
      wr_exp_q.push_back(wb + 32'(i) * 32'd4);
    end
    frame_armed = (tot != 0);
    done_base = done_cnt;
    @(negedge clk);
    enable = 1'b1;
    @(negedge clk);
    enable = 1'b0;
    if (tot == 0) begin
      @(negedge clk);
      zero_expect = 1'b1;
      @(negedge clk);
      zero_expect = 1'b0;
    end
  endtask

  task automatic wait_done(input int budget);
    int k;
    k = 0;
    while (done_cnt == done_base && k < budget) begin
      @(negedge clk);
      k++;
    end
    if (done_cnt == done_base) begin
      n_cmp++;
      n_err++;
      $display("FAIL done_timeout: no done within %0d cycles", budget);
    end
    repeat (2) @(negedge clk);
    chk("done_count", 32'(done_cnt - done_base), 32'd1);
  endtask

  initial begin
    int k;
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    // reset state
    repeat (2) @(negedge clk);
    chk("rst_rd_req", 32'(rd_req), 32'd0);
    chk("rst_wr_req", 32'(wr_req), 32'd0);
    chk("rst_res_ready", 32'(res_ready), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_rd_addr", rd_addr, 32'd0);
    chk("rst_wr_addr", wr_addr, 32'd0);
    chk("rst_state", 32'(state), 32'(IDLE));
    rst = 1'b0;
    @(negedge clk);

    // 4x2 frame, immediate acks; reads and writes overlap
    rd_ack_delay = 0;
    res_on = 1'b1;
    wr_ack_on = 1'b1;
    start_frame(4, 2, 32'h1000, 32'h2000);
    wait_done(50);
    chk("t1_rd_count", 32'(rd_log.size()), 32'd2);
    chk("t1_rd0", log_at(rd_log, 0), 32'h1000);
    chk("t1_rd1", log_at(rd_log, 1), 32'h1004);
    chk("t1_wr0", log_at(wr_log, 0), 32'h2000);
    chk("t1_wr1", log_at(wr_log, 1), 32'h2004);
    chk("t5_both_ack", 32'(both_fire_seen), 32'd1);

    // partial last word
    start_frame(5, 1, 32'h100, 32'h200);
    wait_done(50);
    chk("t2_rd_count", 32'(rd_log.size()), 32'd2);
    chk("t2_rd1", log_at(rd_log, 1), 32'h104);
    chk("t2_wr_count", 32'(wr_log.size()), 32'd2);

    // empty frames
    start_frame(0, 7, 32'h100, 32'h200);
    wait_done(20);
    chk("t2_w0_reqs", 32'(rd_req_cycles), 32'd0);
    start_frame(3, 0, 32'h100, 32'h200);
    wait_done(20);
    chk("t2_h0_reqs", 32'(rd_req_cycles), 32'd0);

    // buf_full gating and a delayed ack held across buf_full
    res_on = 1'b0;
    buf_full = 1'b1;
    start_frame(4, 1, 32'h500, 32'h600);
    repeat (6) @(negedge clk);
    chk("t3_no_rise", 32'(rd_req_cycles), 32'd0);
    rd_ack_delay = 3;
    buf_full = 1'b0;
    k = 0;
    while (!rd_req && k < 20) begin
      @(negedge clk);
      k++;
    end
    chk("t3_rd_req_rose", 32'(rd_req), 32'd1);
    buf_full = 1'b1;
    repeat (8) @(negedge clk);
    buf_full = 1'b0;
    res_on = 1'b1;
    wait_done(50);
    chk("t3_rd_count", 32'(rd_log.size()), 32'd1);
    chk("t3_rd_cycles", 32'(rd_req_cycles), 32'd4);
    chk("t3_rd0", log_at(rd_log, 0), 32'h500);

    // address wrap
    rd_ack_delay = 0;
    start_frame(8, 1, 32'hFFFF_FFFC, 32'hFFFF_FFFC);
    wait_done(50);
    chk("t4_rd0", log_at(rd_log, 0), 32'hFFFF_FFFC);
    chk("t4_rd1", log_at(rd_log, 1), 32'h0000_0000);
    chk("t4_wr1", log_at(wr_log, 1), 32'h0000_0000);

    // reset mid-frame with rd_req pending, then a clean rerun
    rd_ack_delay = 1000;
    res_on = 1'b0;
    start_frame(16, 1, 32'h3000, 32'h4000);
    k = 0;
    while (!rd_req && k < 20) begin
      @(negedge clk);
      k++;
    end
    chk("t6_rd_req_pending", 32'(rd_req), 32'd1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("t6_rd_req", 32'(rd_req), 32'd0);
    chk("t6_wr_req", 32'(wr_req), 32'd0);
    chk("t6_res_ready", 32'(res_ready), 32'd0);
    chk("t6_busy", 32'(busy), 32'd0);
    chk("t6_done", 32'(done), 32'd0);
    chk("t6_rd_addr", rd_addr, 32'd0);
    chk("t6_wr_addr", wr_addr, 32'd0);
    chk("t6_state", 32'(state), 32'(IDLE));
    @(negedge clk);
    rst = 1'b0;
    rd_ack_delay = 0;
    res_on = 1'b1;
    repeat (3) @(negedge clk);
    chk("t6_no_done", 32'(done_cnt - done_base), 32'd0);
    start_frame(16, 1, 32'h3000, 32'h4000);
    wait_done(60);
    chk("t6_rd_count", 32'(rd_log.size()), 32'd4);
    chk("t6_rd0", log_at(rd_log, 0), 32'h3000);
    chk("t6_rd3", log_at(rd_log, 3), 32'h300C);
    chk("t6_wr0", log_at(wr_log, 0), 32'h4000);

    res_on = 1'b0;
    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
